// File: rtl/npn_pkg.sv
// Shared definitions for the NPN canonicalizer: search constants, permutation table,
// transform record and FSM states.
// Pure declarations, no logic of its own.
package npn_pkg;

  localparam int NUM_PERM = 24;
  localparam int NUM_NEG  = 16;
  localparam int NUM_CAND = NUM_PERM * NUM_NEG;

  localparam int TT_W   = 16;
  localparam int PERM_W = 5;
  localparam int NEG_W  = 4;
  localparam int CNT_W  = 9;

  // Element [j] names the input variable that feeds position j.
  typedef logic [3:0][1:0] perm_t;

  typedef struct packed {
    logic [PERM_W-1:0] perm;
    logic [NEG_W-1:0]  neg;
    logic              oneg;
  } npn_xform_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } npn_state_t;

  function automatic perm_t mk_perm(input int a, input int b, input int c, input int d);
    perm_t r;
    r[0] = 2'(a);
    r[1] = 2'(b);
    r[2] = 2'(c);
    r[3] = 2'(d);
    return r;
  endfunction

  // All 24 permutations of {0,1,2,3} in lexicographic order.
  localparam perm_t PERM_TAB [NUM_PERM] = '{
    mk_perm(0,1,2,3), mk_perm(0,1,3,2), mk_perm(0,2,1,3), mk_perm(0,2,3,1),
    mk_perm(0,3,1,2), mk_perm(0,3,2,1), mk_perm(1,0,2,3), mk_perm(1,0,3,2),
    mk_perm(1,2,0,3), mk_perm(1,2,3,0), mk_perm(1,3,0,2), mk_perm(1,3,2,0),
    mk_perm(2,0,1,3), mk_perm(2,0,3,1), mk_perm(2,1,0,3), mk_perm(2,1,3,0),
    mk_perm(2,3,0,1), mk_perm(2,3,1,0), mk_perm(3,0,1,2), mk_perm(3,0,2,1),
    mk_perm(3,1,0,2), mk_perm(3,1,2,0), mk_perm(3,2,0,1), mk_perm(3,2,1,0)
  };

  // Out-of-range indices (24..31) fall back to identity so the lookup is total.
  function automatic perm_t perm_lookup(input logic [PERM_W-1:0] p);
    perm_t r;
    r = mk_perm(0,1,2,3);
    if (int'(p) < NUM_PERM) r = PERM_TAB[p];
    return r;
  endfunction

endpackage

// File: rtl/npn_apply.sv
// Applies an input permutation and input negation to a 4-input truth table.
// Purely combinational, zero latency.
// No flow control; the parent decides when the result is used.
module npn_apply
  import npn_pkg::*;
(
  input  logic [TT_W-1:0]   i_tt,
  input  logic [PERM_W-1:0] i_perm,
  input  logic [NEG_W-1:0]  i_neg,
  output logic [TT_W-1:0]   o_tt
);

  perm_t      w_pm;
  logic [3:0] w_m;
  logic [3:0] w_z;

  // g[m] = f[z], z[j] = m[P[j]] ^ n[j]
  always_comb begin
    o_tt = '0;
    w_m  = '0;
    w_z  = '0;
    w_pm = perm_lookup(i_perm);
    for (int m = 0; m < TT_W; m++) begin
      w_m = 4'(m);
      for (int j = 0; j < 4; j++) begin
        w_z[j] = w_m[w_pm[j]] ^ i_neg[j];
      end
      o_tt[m] = i_tt[w_z];
    end
  end

endmodule

// File: rtl/npn_canon.sv
// Exhaustive NPN canonicalizer for 4-input functions: one (perm, neg) pair per cycle.
// Fixed latency: out_valid rises 385 cycles after the accept edge.
// in_ready only in IDLE; result held in DONE until out_ready.
module npn_canon
  import npn_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [TT_W-1:0]   in_tt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TT_W-1:0]   out_tt,
  output logic [PERM_W-1:0] out_perm,
  output logic [NEG_W-1:0]  out_neg,
  output logic              out_oneg
);

  npn_state_t        r_state;
  npn_state_t        w_state_nxt;
  logic [TT_W-1:0]   r_tt;
  logic [CNT_W-1:0]  r_cnt;
  logic [TT_W-1:0]   r_best;
  npn_xform_t        r_best_x;

  logic [PERM_W-1:0] w_perm;
  logic [NEG_W-1:0]  w_neg;
  logic [TT_W-1:0]   w_app;
  logic [TT_W-1:0]   w_inv;
  logic [TT_W-1:0]   w_cand;
  logic              w_oneg;
  logic              w_eval;
  logic              w_take;
  logic              w_accept;

  // Counter splits directly into the (p, n) pair: p outer, n inner.
  assign w_perm = r_cnt[CNT_W-1 -: PERM_W];
  assign w_neg  = r_cnt[NEG_W-1:0];

  npn_apply u_apply (
    .i_tt   (r_tt),
    .i_perm (w_perm),
    .i_neg  (w_neg),
    .o_tt   (w_app)
  );

  // g and ~g never tie, so picking the smaller one also honours o=0-first.
  assign w_inv    = ~w_app;
  assign w_oneg   = (w_inv < w_app);
  assign w_cand   = w_oneg ? w_inv : w_app;
  // The counter stops at NUM_CAND; that final SEARCH cycle evaluates nothing.
  assign w_eval   = (r_state == SEARCH) && (r_cnt < CNT_W'(NUM_CAND));
  assign w_take   = w_eval && (w_cand < r_best);
  assign w_accept = (r_state == IDLE) && in_valid;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next-state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)                     w_state_nxt = SEARCH;
      SEARCH:  if (r_cnt == CNT_W'(NUM_CAND))    w_state_nxt = DONE;
      DONE:    if (out_ready)                    w_state_nxt = IDLE;
      default:                                   w_state_nxt = IDLE;
    endcase
  end

  // Search datapath: latch input on accept, then step the counter and track the minimum
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tt     <= '0;
      r_cnt    <= '0;
      r_best   <= '0;
      r_best_x <= '0;
    end else if (w_accept) begin
      r_tt     <= in_tt;
      r_cnt    <= '0;
      r_best   <= '1;
      r_best_x <= '0;
    end else if (w_eval) begin
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_take) begin
        r_best        <= w_cand;
        r_best_x.perm <= w_perm;
        r_best_x.neg  <= w_neg;
        r_best_x.oneg <= w_oneg;
      end
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign out_tt    = r_best;
  assign out_perm  = r_best_x.perm;
  assign out_neg   = r_best_x.neg;
  assign out_oneg  = r_best_x.oneg;

endmodule

// File: doc/npn_canon.md
NPN_CANON -- requirements
Module: npn_canon

Interface
REQ-001 The block SHALL have the port clk, input, width 1: the single clock, with all state updating on its rising edge.
REQ-002 The block SHALL have the port rst, input, width 1: asynchronous, active-high reset.
REQ-003 The block SHALL have the port in_valid, input, width 1: in_tt holds a function to canonicalize.
REQ-004 The block SHALL have the port in_ready, output, width 1: the block accepts a new function.
REQ-005 The block SHALL have the port in_tt, input, width 16: the input truth table, where bit m = f(x0=m[0], x1=m[1], x2=m[2], x3=m[3]).
REQ-006 The block SHALL have the port out_valid, output, width 1: the result fields are valid.
REQ-007 The block SHALL have the port out_ready, input, width 1: the consumer accepts the result.
REQ-008 The block SHALL have the port out_tt, output, width 16: the canonical (NPN-minimum) truth table.
REQ-009 The block SHALL have the port out_perm, output, width 5: the permutation index, 0..23.
REQ-010 The block SHALL have the port out_neg, output, width 4: the input negation mask.
REQ-011 The block SHALL have the port out_oneg, output, width 1: the output negation.

Function
REQ-012 A transform (p, n, o) SHALL map f to g with g[m] = f[z] ^ o, where z[j] = m[P[p][j]] ^ n[j].
- P is the table of the 24 permutations of {0,1,2,3} in lexicographic order.
- P[0] = (0,1,2,3); P[18] = (3,0,1,2).
REQ-013 The canonical form SHALL be the numerically smallest g over all 768 transforms; out_tt, out_perm, out_neg and out_oneg SHALL report that g and its transform.
REQ-014 Tie-break: the first transform reaching the minimum in search order SHALL win.
- Order: p is the outer loop (0..23), n is the inner loop (0..15).
- Within one (p, n), o=0 is preferred over o=1 on equality.
REQ-015 FSM states SHALL be IDLE, SEARCH and DONE.
REQ-016 In IDLE, in_ready SHALL be 1; an in_valid&in_ready cycle SHALL latch in_tt, clear the 9-bit candidate counter, set best to 16'hFFFF with no transform, and go to SEARCH.
REQ-017 In SEARCH, exactly one (p, n) SHALL be evaluated per cycle, with both o=0 and o=1 compared combinationally against best; a strictly smaller candidate SHALL replace best and its transform.
REQ-018 The transition SEARCH -> DONE SHALL occur after candidate (23,15) is evaluated (384 SEARCH cycles); the counter SHALL NOT wrap.
REQ-019 In DONE, out_valid SHALL be 1 and all outputs SHALL be held stable until out_valid&out_ready, which SHALL return the FSM to IDLE.
REQ-020 Latency SHALL be fixed: out_valid rises 385 cycles after the accept edge, independent of data.
REQ-021 in_ready SHALL be 0 in SEARCH and DONE; in_valid there SHALL be ignored, and the held in_tt SHALL be unaffected by in_tt changes.
REQ-022 out_ready asserted while out_valid=0 SHALL have no effect.
REQ-023 out_ready held high in DONE SHALL give a 1-cycle out_valid pulse, followed by in_ready=1 on the next cycle.

Reset
REQ-024 Asserting rst at any time, including mid-SEARCH, SHALL immediately force IDLE.
REQ-025 Reset values SHALL be: in_ready=1, out_valid=0, out_tt=16'h0000, out_perm=0, out_neg=0, out_oneg=0, counter=0.
REQ-026 A search interrupted by reset SHALL produce no output.

Structure
REQ-027 The shared package npn_pkg SHALL hold:
- the 24-entry permutation table P;
- the constants NUM_PERM=24, NUM_NEG=16, NUM_CAND=384;
- the transform-field widths;
- the typedef npn_xform_t {perm[4:0], neg[3:0], oneg}.
REQ-028 Combinational sub-module npn_apply SHALL be instantiated once, taking (tt, perm, neg) and producing the transformed 16-bit table; output negation is applied in the parent.

Verification
REQ-029 Scenario: in_tt=16'h0000 -> after 385 cycles out_tt=16'h0000, perm=0, neg=0, oneg=0.
REQ-030 Scenario: in_tt=16'hFFFF -> out_tt=16'h0000, perm=0, neg=0, oneg=1.
REQ-031 Scenario: in_tt=16'hAAAA (x0) -> out_tt=16'h00FF, perm=18, neg=4'h0, oneg=1.
REQ-032 Scenario: in_tt=16'h8000 (AND4) -> out_tt=16'h0001, perm=0, neg=4'hF, oneg=0.
REQ-033 Scenario: backpressure with out_ready=0 for 50 cycles in DONE -> outputs stable and in_ready=0 throughout; one out_ready cycle returns to IDLE.
REQ-034 Scenario: rst pulse at SEARCH cycle 200, then in_tt=16'h6996 -> no stale output; out_tt=16'h6996 (XOR4 is NPN-invariant, minimum is 6996), perm=0, neg=0, oneg=0.
